mem_load_unit: RTL and testbench

MEM-stage load engine that consumes the EX/MEM pipeline register outputs and produces the MEM/WB writeback triple. Non-load instructions pass through in one cycle. Loads (`memread_MEM` with a non-zero byte mask) issue a valid/ready request to data memory, stall the front of the pipeline until the response returns, then extract and zero-extend the masked bytes. It sits between the EX/MEM register and the MEM/WB register, and owns the data-memory read port.

---
 rtl/mem_load_unit.sv | 161 ++++++++++++++++
 tb/tb_mem_load_unit.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_load_unit.sv
// mem_load_unit: MEM-stage load engine; stalls the pipeline on loads and returns zero-extended masked bytes.
// Optional feature macro: MEM_LOAD_TIMEOUT_EN (WAIT-state timeout, load_err pulse, late-response drop).
`default_nettype none

module mem_load_unit #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread_MEM,
   input  logic        regwrite_MEM,
   input  logic [3:0]  mask_MEM,
   input  logic [4:0]  rd_MEM,
   input  logic [31:0] ALU_data_MEM,
   output logic        stall_MEM,
   output logic        dmem_req_valid,
   input  logic        dmem_req_ready,
   output logic [31:0] dmem_req_addr,
   input  logic        dmem_rsp_valid,
   input  logic [31:0] dmem_rsp_data,
   output logic        regwrite_WB,
   output logic [4:0]  rd_WB,
   output logic [31:0] data_WB
`ifdef MEM_LOAD_TIMEOUT_EN
   ,
   output logic        load_err
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_mask;
   logic [4:0]  r_rd;
   logic        r_regwrite;

   logic        w_load;
   logic        w_rsp;
   logic        w_tmo;
   logic [31:0] w_lane;
   logic [4:0]  w_shift;
   logic [31:0] w_extract;

   assign w_load = memread_MEM && (mask_MEM != 4'b0000);

   // Masked bytes keep their relative positions; the lowest selected byte lands in [7:0].
   always_comb begin
      w_lane = {{8{r_mask[3]}}, {8{r_mask[2]}}, {8{r_mask[1]}}, {8{r_mask[0]}}};
      w_shift = 5'd24;
      if (r_mask[0])      w_shift = 5'd0;
      else if (r_mask[1]) w_shift = 5'd8;
      else if (r_mask[2]) w_shift = 5'd16;
      w_extract = (dmem_rsp_data & w_lane) >> w_shift;
   end

`ifdef MEM_LOAD_TIMEOUT_EN
   localparam int c_CNT_W = $clog2(TIMEOUT + 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               r_drop;

   // A response owed to a timed-out load is swallowed once, whatever state we are in.
   assign w_rsp = dmem_rsp_valid && !r_drop;
   assign w_tmo = (r_state == S_WAIT) && !w_rsp && (r_cnt == c_CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_drop   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_err <= w_tmo;
         if (r_state != S_WAIT)
            r_cnt <= '0;
         else if (!w_rsp)
            r_cnt <= r_cnt + 1'b1;
         if (w_tmo)
            r_drop <= 1'b1;
         else if (dmem_rsp_valid)
            r_drop <= 1'b0;
      end
   end
`else
   localparam int c_unused_timeout = TIMEOUT;

   assign w_rsp = dmem_rsp_valid;
   assign w_tmo = 1'b0;
`endif

   always_comb begin
      stall_MEM = 1'b0;
      case (r_state)
         S_IDLE:  stall_MEM = w_load;
         S_REQ:   stall_MEM = 1'b1;
         S_WAIT:  stall_MEM = !(w_rsp || w_tmo);
         default: stall_MEM = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_mask         <= 4'b0000;
         r_rd           <= 5'd0;
         r_regwrite     <= 1'b0;
         dmem_req_valid <= 1'b0;
         dmem_req_addr  <= 32'd0;
         regwrite_WB    <= 1'b0;
         rd_WB          <= 5'd0;
         data_WB        <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_load) begin
                  r_mask         <= mask_MEM;
                  r_rd           <= rd_MEM;
                  r_regwrite     <= regwrite_MEM;
                  dmem_req_addr  <= {ALU_data_MEM[31:2], 2'b00};
                  dmem_req_valid <= 1'b1;
                  regwrite_WB    <= 1'b0;
                  r_state        <= S_REQ;
               end else begin
                  regwrite_WB <= regwrite_MEM;
                  rd_WB       <= rd_MEM;
                  data_WB     <= ALU_data_MEM;
               end
            end
            S_REQ: begin
               regwrite_WB <= 1'b0;
               if (dmem_req_ready) begin
                  dmem_req_valid <= 1'b0;
                  r_state        <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_rsp) begin
                  regwrite_WB <= r_regwrite;
                  rd_WB       <= r_rd;
                  data_WB     <= w_extract;
                  r_state     <= S_IDLE;
               end else begin
                  regwrite_WB <= 1'b0;
                  if (w_tmo)
                     r_state <= S_IDLE;
               end
            end
            default: begin
               dmem_req_valid <= 1'b0;
               r_state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed vector tables, reset/timeout sequences and randomized traffic against a reference model.
// Exercises the MEM_LOAD_TIMEOUT_EN path when that macro is defined.
`default_nettype none

module tb_mem_load_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        memread_MEM, regwrite_MEM;
   logic [3:0]  mask_MEM;
   logic [4:0]  rd_MEM;
   logic [31:0] ALU_data_MEM;
   logic        stall_MEM, dmem_req_valid, dmem_req_ready;
   logic [31:0] dmem_req_addr;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_data;
   logic        regwrite_WB;
   logic [4:0]  rd_WB;
   logic [31:0] data_WB;
`ifdef MEM_LOAD_TIMEOUT_EN
   logic        load_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_load_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .memread_MEM(memread_MEM), .regwrite_MEM(regwrite_MEM), .mask_MEM(mask_MEM),
      .rd_MEM(rd_MEM), .ALU_data_MEM(ALU_data_MEM), .stall_MEM(stall_MEM),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_addr(dmem_req_addr), .dmem_rsp_valid(dmem_rsp_valid),
      .dmem_rsp_data(dmem_rsp_data), .regwrite_WB(regwrite_WB), .rd_WB(rd_WB),
      .data_WB(data_WB)
`ifdef MEM_LOAD_TIMEOUT_EN
      , .load_err(load_err)
`endif
   );

   typedef struct {
      logic        mr;
      logic        rw;
      logic [3:0]  mask;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        exp_rw;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
   } alu_vec_t;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] rsp;
      int          ready_lo;
      int          rsp_dly;
      logic [31:0] exp_data;
      logic [31:0] exp_addr;
   } load_vec_t;

   alu_vec_t  av[4];
   load_vec_t lv[8];

   // Random-traffic model state
   logic        have, c_mr, c_rw, is_load, seen, acc, drv_rsp, exp_stall, exp_valid;
   logic [3:0]  c_mask;
   logic [4:0]  c_rd, e_rd;
   logic [31:0] c_alu, word, e_data;
   logic        e_rw;
   int          wait_n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mr, input logic rw, input logic [3:0] m,
                        input logic [4:0] rd, input logic [31:0] alu);
      memread_MEM  = mr;
      regwrite_MEM = rw;
      mask_MEM     = m;
      rd_MEM       = rd;
      ALU_data_MEM = alu;
   endtask

   // Selected bytes keep their positions relative to the lowest selected byte.
   function automatic logic [31:0] ref_extract(input logic [31:0] w, input logic [3:0] m);
      int lo;
      logic [31:0] r;
      lo = 0;
      r  = 32'd0;
      for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
      for (int i = 0; i < 4; i++) if (m[i]) r[8*(i-lo) +: 8] = w[8*i +: 8];
      return r;
   endfunction

   task automatic run_load(input load_vec_t v, input int idx);
      int          stalls;
      logic [4:0]  hrd, lrd;
      logic [31:0] hdata;
      hrd   = 5'(idx + 1);
      lrd   = 5'(idx + 16);
      hdata = 32'hA5A50000 | idx;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      drive(1'b0, 1'b1, 4'h0, hrd, hdata);
      #1 check("pre_alu_stall", stall_MEM, 0);
      tick();
      drive(1'b1, 1'b1, v.mask, lrd, v.addr);
      stalls = 0;
      #1 check("detect_stall", stall_MEM, 1);
      check("detect_valid", dmem_req_valid, 0);
      stalls += stall_MEM;
      tick();
      for (int k = 0; k <= v.ready_lo; k++) begin
         dmem_req_ready = (k == v.ready_lo);
         #1 check("req_valid", dmem_req_valid, 1);
         check("req_addr", dmem_req_addr, v.exp_addr);
         check("req_stall", stall_MEM, 1);
         check("req_bubble_rw", regwrite_WB, 0);
         check("req_hold_rd", rd_WB, hrd);
         check("req_hold_data", data_WB, hdata);
         stalls += stall_MEM;
         tick();
      end
      dmem_req_ready = 1'b0;
      for (int k = 0; k <= v.rsp_dly; k++) begin
         dmem_rsp_valid = (k == v.rsp_dly);
         dmem_rsp_data  = (k == v.rsp_dly) ? v.rsp : 32'h0BAD0BAD;
         #1 check("wait_valid", dmem_req_valid, 0);
         check("wait_stall", stall_MEM, (k != v.rsp_dly));
         check("wait_bubble_rw", regwrite_WB, 0);
         stalls += stall_MEM;
         tick();
      end
      dmem_rsp_valid = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      check("load_rw", regwrite_WB, 1);
      check("load_rd", rd_WB, lrd);
      check("load_data", data_WB, v.exp_data);
      check("stall_cycles", stalls, 2 + v.ready_lo + v.rsp_dly);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      av[0] = '{1'b0, 1'b1, 4'h0, 5'd5,  32'h00001234, 1'b1, 5'd5,  32'h00001234};
      av[1] = '{1'b1, 1'b1, 4'h0, 5'd7,  32'hCAFE0000, 1'b1, 5'd7,  32'hCAFE0000};
      av[2] = '{1'b0, 1'b0, 4'hF, 5'd9,  32'h00000055, 1'b0, 5'd9,  32'h00000055};
      av[3] = '{1'b0, 1'b1, 4'h0, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'hFFFFFFFF};

      lv[0] = '{4'hF, 32'h00000103, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h00000100};
      lv[1] = '{4'hC, 32'h00000200, 32'hAABBCCDD, 0, 0, 32'h0000AABB, 32'h00000200};
      lv[2] = '{4'h2, 32'h00000204, 32'hAABBCCDD, 0, 0, 32'h000000CC, 32'h00000204};
      lv[3] = '{4'h5, 32'h000003FE, 32'h11223344, 0, 0, 32'h00220044, 32'h000003FC};
      lv[4] = '{4'h6, 32'h00000010, 32'h11223344, 0, 0, 32'h00002233, 32'h00000010};
      lv[5] = '{4'hA, 32'h00000021, 32'h11223344, 0, 0, 32'h00110033, 32'h00000020};
      lv[6] = '{4'h8, 32'h00000030, 32'h80FFFFFF, 0, 0, 32'h00000080, 32'h00000030};
      lv[7] = '{4'hF, 32'h00000044, 32'h12345678, 3, 1, 32'h12345678, 32'h00000044};

      reset          = 1'b1;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rsp_data  = 32'd0;
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      tick();
      tick();
      check("rst_valid", dmem_req_valid, 0);
      check("rst_addr", dmem_req_addr, 0);
      check("rst_rw", regwrite_WB, 0);
      check("rst_rd", rd_WB, 0);
      check("rst_data", data_WB, 0);
      check("rst_stall", stall_MEM, 0);
      reset = 1'b0;
      tick();

      foreach (av[i]) begin
         drive(av[i].mr, av[i].rw, av[i].mask, av[i].rd, av[i].alu);
         #1 check("alu_stall", stall_MEM, 0);
         tick();
         check("alu_rw", regwrite_WB, av[i].exp_rw);
         check("alu_rd", rd_WB, av[i].exp_rd);
         check("alu_data", data_WB, av[i].exp_data);
      end

      foreach (lv[i]) run_load(lv[i], i);

      // Reset while the request is pending drops valid without a clock edge.
      drive(1'b1, 1'b1, 4'hF, 5'd4, 32'h00000040);
      tick();
      #1 check("rreq_valid", dmem_req_valid, 1);
      reset = 1'b1;
      #1 check("rreq_valid_drop", dmem_req_valid, 0);
      check("rreq_addr", dmem_req_addr, 0);
      reset = 1'b0;
      tick();

      // Reset during WAIT.
      drive(1'b0, 1'b1, 4'h0, 5'd9, 32'h00000099);
      tick();
      drive(1'b1, 1'b1, 4'hF, 5'd4, 32'h00000040);
      dmem_req_ready = 1'b1;
      tick();
      tick();
      dmem_req_ready = 1'b0;
      #1 check("rwait_stall", stall_MEM, 1);
      reset = 1'b1;
      #1 check("rwait_valid", dmem_req_valid, 0);
      check("rwait_rw", regwrite_WB, 0);
      check("rwait_rd", rd_WB, 0);
      check("rwait_data", data_WB, 0);
      check("rwait_addr", dmem_req_addr, 0);
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      #1 check("rwait_idle_stall", stall_MEM, 0);
      reset = 1'b0;
      tick();
      drive(1'b0, 1'b1, 4'h0, 5'd5, 32'h00001234);
      #1 check("post_rst_stall", stall_MEM, 0);
      tick();
      check("post_rst_rw", regwrite_WB, 1);
      check("post_rst_rd", rd_WB, 5);
      check("post_rst_data", data_WB, 32'h00001234);

      // Randomized traffic against the transaction-level model.
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      tick();
      e_rw = 1'b0; e_rd = 5'd0; e_data = 32'd0;
      have = 1'b0; is_load = 1'b0; seen = 1'b0; acc = 1'b0; wait_n = 0;
      c_mr = 1'b0; c_rw = 1'b0; c_mask = 4'h0; c_rd = 5'd0; c_alu = 32'd0; word = 32'd0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         if (!have) begin
            c_mr    = 1'($urandom_range(0, 1));
            c_rw    = 1'($urandom);
            c_mask  = 4'($urandom);
            c_rd    = 5'($urandom);
            c_alu   = $urandom;
            word    = $urandom;
            is_load = c_mr && (c_mask != 4'h0);
            seen    = 1'b0;
            acc     = 1'b0;
            have    = 1'b1;
         end
         drive(c_mr, c_rw, c_mask, c_rd, c_alu);
         dmem_req_ready = ($urandom_range(0, 2) != 0);
         drv_rsp        = is_load && acc && (wait_n == 0);
         dmem_rsp_valid = drv_rsp;
         dmem_rsp_data  = drv_rsp ? word : $urandom;
         #1 check("rnd_rw", regwrite_WB, e_rw);
         check("rnd_rd", rd_WB, e_rd);
         check("rnd_data", data_WB, e_data);
         exp_stall = is_load && !drv_rsp;
         exp_valid = is_load && seen && !acc;
         check("rnd_stall", stall_MEM, exp_stall);
         check("rnd_valid", dmem_req_valid, exp_valid);
         if (exp_valid) check("rnd_addr", dmem_req_addr, {c_alu[31:2], 2'b00});
         if (!exp_stall) begin
            e_rw   = c_rw;
            e_rd   = c_rd;
            e_data = is_load ? ref_extract(word, c_mask) : c_alu;
            have   = 1'b0;
         end else begin
            e_rw = 1'b0;
         end
         if (is_load) begin
            if (exp_valid && dmem_req_ready) begin
               acc    = 1'b1;
               wait_n = $urandom_range(0, 2);
            end else if (acc && wait_n > 0) begin
               wait_n--;
            end
            seen = 1'b1;
         end
         tick();
      end
      dmem_rsp_valid = 1'b0;
      dmem_req_ready = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      tick();

`ifdef MEM_LOAD_TIMEOUT_EN
      drive(1'b1, 1'b1, 4'hF, 5'd3, 32'h00000080);
      #1 check("tmo_detect_stall", stall_MEM, 1);
      tick();
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1 check("tmo_stall", stall_MEM, (k < 3));
         check("tmo_err_early", load_err, 0);
         tick();
      end
      drive(1'b0, 1'b0, 4'h0, 5'd0, 32'd0);
      #1 check("tmo_err_pulse", load_err, 1);
      check("tmo_bubble", regwrite_WB, 0);
      tick();
      check("tmo_err_clear", load_err, 0);
      dmem_rsp_valid = 1'b1;
      dmem_rsp_data  = 32'hBADBAD00;
      #1 check("tmo_late_stall", stall_MEM, 0);
      tick();
      dmem_rsp_valid = 1'b0;
      check("tmo_late_rw", regwrite_WB, 0);
      run_load(lv[1], 20);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
